// File: rtl/mem_refill_ctrl.sv
// Miss-service controller for a cache: writes back a dirty victim block, then fetches
// the missing 16-word block from main memory and hands it to the cache.
module mem_refill_ctrl #(
    parameter int MEM_LATENCY = 1,
    parameter int WB_CYCLES   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    input  logic         victim_dirty,
    input  logic [31:0]  victim_addr,
    input  logic [511:0] victim_data,
    output logic         busy,
    output logic         refill_valid,
    output logic [31:0]  refill_addr,
    output logic [511:0] refill_data,
    output logic [31:0]  req_word,
    output logic [31:0]  mem_addr,
    output logic         mem_rd_en,
    output logic         mem_wr_en,
    output logic [511:0] mem_wr_data,
    input  logic [511:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, WRITEBACK, READ, READ_WAIT, DONE} state_t;

    localparam int CNT_MAX = (MEM_LATENCY > WB_CYCLES) ? MEM_LATENCY : WB_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] WB_LAST = CW'(WB_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(MEM_LATENCY - 1);
    localparam logic [31:0]   BLK_MASK = 32'hFFFF_FFF0;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           capture;
    logic [31:0]    miss_q, victim_q;
    logic [511:0]   victim_data_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no branch can infer a latch.
        state_d = state;
        cnt_d   = '0;
        capture = 1'b0;
        case (state)
            IDLE:      if (miss_req) state_d = victim_dirty ? WRITEBACK : READ;
            WRITEBACK: if (cnt == WB_LAST) state_d = READ;
                       else cnt_d = cnt + 1'b1;
            READ:      state_d = READ_WAIT;
            READ_WAIT: if (cnt == RD_LAST) begin
                           state_d = DONE;
                           capture = 1'b1;
                       end else begin
                           cnt_d = cnt + 1'b1;
                       end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign busy         = (state != IDLE);
    assign refill_valid = (state == DONE);
    assign mem_rd_en    = (state == READ) || (state == READ_WAIT);
    assign mem_wr_en    = (state == WRITEBACK) && (cnt == '0);
    assign mem_addr     = (state == WRITEBACK) ? (victim_q & BLK_MASK) : (miss_q & BLK_MASK);
    assign mem_wr_data  = victim_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            miss_q        <= '0;
            victim_q      <= '0;
            victim_data_q <= '0;
            refill_addr   <= '0;
            refill_data   <= '0;
            req_word      <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && miss_req) begin
                miss_q        <= miss_addr;
                victim_q      <= victim_addr;
                victim_data_q <= victim_data;
            end
            if (capture) begin
                refill_data <= mem_rdata;
                refill_addr <= miss_q & BLK_MASK;
                req_word    <= mem_rdata[{miss_q[3:0], 5'b0} +: 32];
            end
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Bench for mem_refill_ctrl: two instances (latency 1/wb 1 and latency 3/wb 2) driven by
// directed and random misses, checked against a transaction-level model of the refill.
module tb_mem_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst          [2];
    logic         miss_req     [2];
    logic [31:0]  miss_addr    [2];
    logic         victim_dirty [2];
    logic [31:0]  victim_addr  [2];
    logic [511:0] victim_data  [2];
    logic         busy         [2];
    logic         refill_valid [2];
    logic [31:0]  refill_addr  [2];
    logic [511:0] refill_data  [2];
    logic [31:0]  req_word     [2];
    logic [31:0]  mem_addr     [2];
    logic         mem_rd_en    [2];
    logic         mem_wr_en    [2];
    logic [511:0] mem_wr_data  [2];
    logic [511:0] mem_rdata    [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int wbc(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Word k of block B holds the value B+k.
    function automatic logic [511:0] blk_pattern(input logic [31:0] base);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = base + 32'(k);
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        int rd_cnt = 0;

        mem_refill_ctrl #(
            .MEM_LATENCY(gi == 0 ? 1 : 3),
            .WB_CYCLES  (gi == 0 ? 1 : 2)
        ) u_dut (
            .clk         (clk),
            .reset       (rst[gi]),
            .miss_req    (miss_req[gi]),
            .miss_addr   (miss_addr[gi]),
            .victim_dirty(victim_dirty[gi]),
            .victim_addr (victim_addr[gi]),
            .victim_data (victim_data[gi]),
            .busy        (busy[gi]),
            .refill_valid(refill_valid[gi]),
            .refill_addr (refill_addr[gi]),
            .refill_data (refill_data[gi]),
            .req_word    (req_word[gi]),
            .mem_addr    (mem_addr[gi]),
            .mem_rd_en   (mem_rd_en[gi]),
            .mem_wr_en   (mem_wr_en[gi]),
            .mem_wr_data (mem_wr_data[gi]),
            .mem_rdata   (mem_rdata[gi])
        );

        // Memory returns valid data only once rd_en has been sampled for the full latency.
        always @(posedge clk) rd_cnt <= mem_rd_en[gi] ? rd_cnt + 1 : 0;
        assign mem_rdata[gi] = (rd_cnt >= lat(gi)) ? blk_pattern(mem_addr[gi]) : {16{32'hDEAD_BEEF}};
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_busy"},   512'(busy[d]), 512'(0));
        check({tag, "_valid"},  512'(refill_valid[d]), 512'(0));
        check({tag, "_rd_en"},  512'(mem_rd_en[d]), 512'(0));
        check({tag, "_wr_en"},  512'(mem_wr_en[d]), 512'(0));
        check({tag, "_maddr"},  512'(mem_addr[d]), 512'(0));
        check({tag, "_rdata"},  refill_data[d], 512'(0));
        check({tag, "_rword"},  512'(req_word[d]), 512'(0));
    endtask

    // Called just after a falling edge; returns just after the falling edge where busy is low again.
    task automatic run_miss(input int d, input logic [31:0] addr, input logic dirty,
                            input logic [31:0] vaddr, input logic [511:0] vdata,
                            input bit noisy, input bit keep_high);
        logic [31:0]  base  = addr & 32'hFFFF_FFF0;
        int           exp_k = 1 + lat(d) + (dirty ? wbc(d) : 0);
        int           rv_k  = -1;
        int           rv_n  = 0, rd_n = 0, wr_n = 0, ovl = 0;
        bit           addr_ok = 1'b1, busy_ok = 1'b1, idle_seen = 1'b0;
        logic [31:0]  wa = '0;
        logic [511:0] wd = '0;
        miss_req[d]     = 1'b1;
        miss_addr[d]    = addr;
        victim_dirty[d] = dirty;
        victim_addr[d]  = vaddr;
        victim_data[d]  = vdata;
        @(posedge clk);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (mem_rd_en[d] && mem_wr_en[d]) ovl++;
            if (mem_rd_en[d]) begin
                rd_n++;
                if (mem_addr[d] !== base) addr_ok = 1'b0;
            end
            if (mem_wr_en[d]) begin
                wr_n++;
                wa = mem_addr[d];
                wd = mem_wr_data[d];
            end
            if (refill_valid[d]) begin
                rv_n++;
                if (rv_k < 0) rv_k = k;
            end
            if (rv_k >= 0 && k == rv_k + 1) begin
                idle_seen = !busy[d];
                break;
            end
            if (!busy[d]) busy_ok = 1'b0;
            if (rv_k >= 0) begin
                miss_req[d] = keep_high;
            end else if (noisy) begin
                miss_req[d]     = 1'($urandom_range(0, 1));
                miss_addr[d]    = $urandom;
                victim_dirty[d] = 1'($urandom_range(0, 1));
                victim_addr[d]  = $urandom;
            end
        end
        check("latency",     512'(rv_k), 512'(exp_k));
        check("valid_count", 512'(rv_n), 512'(1));
        check("rd_cycles",   512'(rd_n), 512'(1 + lat(d)));
        check("wr_pulses",   512'(wr_n), 512'(dirty));
        check("overlap",     512'(ovl), 512'(0));
        check("rd_addr_ok",  512'(addr_ok), 512'(1));
        check("busy_held",   512'(busy_ok), 512'(1));
        check("busy_drop",   512'(idle_seen), 512'(1));
        if (dirty) begin
            check("wr_addr", 512'(wa), 512'(vaddr & 32'hFFFF_FFF0));
            check("wr_data", wd, vdata);
        end
        check("refill_addr", 512'(refill_addr[d]), 512'(base));
        check("req_word",    512'(req_word[d]), 512'(base + 32'(addr[3:0])));
        check("refill_data", refill_data[d], blk_pattern(base));
    endtask

    initial begin
        int           n_rv;
        logic [511:0] rnd;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            miss_req[d] = 1'b0;
            miss_addr[d] = '0;
            victim_dirty[d] = 1'b0;
            victim_addr[d] = '0;
            victim_data[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d, "reset");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d, "post_reset");

        // Clean miss, then dirty miss with a separate victim block.
        run_miss(0, 32'h0000_1237, 1'b0, 32'h0, '0, 1'b0, 1'b0);
        check("t1_word0",  512'(refill_data[0][31:0]), 512'(32'h1230));
        check("t1_word15", 512'(refill_data[0][511:480]), 512'(32'h123F));
        run_miss(0, 32'h0000_0085, 1'b1, 32'h0000_004C, {16{32'hA5A5_A5A5}}, 1'b0, 1'b0);

        // Request held across DONE restarts immediately; noise while busy is ignored.
        run_miss(0, 32'h2000_0003, 1'b0, 32'h0, '0, 1'b1, 1'b1);
        rnd = {16{$urandom}};
        run_miss(0, 32'h3004_0ABC, 1'b1, 32'h3004_0AB1, rnd, 1'b1, 1'b0);

        // Outputs hold between refills while idle.
        repeat (3) @(negedge clk);
        check("hold_addr", 512'(refill_addr[0]), 512'(32'h3004_0AB0));
        check("hold_word", 512'(req_word[0]), 512'(32'h3004_0ABC));

        // Async reset in READ_WAIT abandons the transfer.
        miss_req[0] = 1'b1;
        miss_addr[0] = 32'h0000_7770;
        victim_dirty[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_rd", 512'(mem_rd_en[0]), 512'(1));
        #2 rst[0] = 1'b1;
        #1 check_idle_outputs(0, "async_reset");
        miss_req[0] = 1'b0;
        n_rv = 0;
        repeat (3) begin
            @(negedge clk);
            if (refill_valid[0] || busy[0]) n_rv++;
        end
        check("reset_no_valid", 512'(n_rv), 512'(0));
        rst[0] = 1'b0;
        run_miss(0, 32'hFFFF_FFFF, 1'b0, 32'h0, '0, 1'b0, 1'b0);

        // Long-latency instance: dirty miss, and victim in the same block as the miss.
        run_miss(1, 32'h0000_0085, 1'b1, 32'h0000_004C, {16{32'hA5A5_A5A5}}, 1'b0, 1'b0);
        run_miss(1, 32'h0001_0009, 1'b1, 32'h0001_0000, {16{32'h1234_5678}}, 1'b1, 1'b0);

        // Random misses on both instances.
        for (int i = 0; i < 24; i++) begin
            int d = i % 2;
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_miss(d, $urandom, 1'($urandom_range(0, 1)), $urandom, rnd,
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
